// File: rtl/adc_read_fsm.sv
// Serial SAR ADC read sequencer: conversion pulse, NBits dclk pulses, MSB-first shift-in.
// Optional macro ADC_CNT_CHECK_EN adds err_o and a shadow pulse count cross-checked against cnt_i.
module adc_read_fsm #(
  parameter int Width      = 6,
  parameter int NBits      = 16,
  parameter int ConvCycles = 50,
  parameter int HalfDiv    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sdo_i,
  input  logic [Width-1:0] cnt_i,
  output logic [1:0]       opc_o,
  output logic             cnv_o,
  output logic             dclk_o,
  output logic [NBits-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
`ifdef ADC_CNT_CHECK_EN
  output logic             err_o,
`endif
  output logic [2:0]       state_o
);

  localparam int TW = $clog2(ConvCycles + HalfDiv);

  typedef enum logic [2:0] {IDLE, CONV, LOW, HIGH, DONE} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [NBits-1:0] shift, shift_n;
  logic [1:0]       opc_n;
  logic             err_flag;
  logic             timer_end;

`ifdef ADC_CNT_CHECK_EN
  logic [Width-1:0] shadow, shadow_n;
`endif

  assign timer_end = (timer == '0);
  assign state_o   = state;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    shift_n  = shift;
    err_flag = 1'b0;
`ifdef ADC_CNT_CHECK_EN
    shadow_n = shadow;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n = CONV;
          timer_n = TW'(ConvCycles - 1);
          shift_n = '0;
`ifdef ADC_CNT_CHECK_EN
          shadow_n = '0;
`endif
        end
      end
      CONV: begin
        if (timer_end) begin
          state_n = LOW;
          timer_n = TW'(HalfDiv - 1);
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      LOW: begin
        if (timer_end) begin
          // Sample on the last LOW cycle, just before the dclk rising edge.
          shift_n = NBits'({shift, sdo_i});
          state_n = HIGH;
          timer_n = TW'(HalfDiv - 1);
`ifdef ADC_CNT_CHECK_EN
          shadow_n = shadow + 1'b1;
`endif
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      HIGH: begin
        if (timer_end) begin
          timer_n = TW'(HalfDiv - 1);
          state_n = (cnt_i == Width'(NBits)) ? DONE : LOW;
`ifdef ADC_CNT_CHECK_EN
          if ((cnt_i > Width'(NBits)) || (cnt_i != shadow)) begin
            state_n  = DONE;
            err_flag = 1'b1;
          end
`endif
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so cnv_o/dclk_o never glitch.
  always_comb begin
    opc_n = 2'b00;
    case (state_n)
      IDLE:    opc_n = 2'b00;
      CONV:    opc_n = 2'b00;
      LOW:     opc_n = 2'b01;
      HIGH:    opc_n = (state == LOW) ? 2'b10 : 2'b01;
      DONE:    opc_n = 2'b11;
      default: opc_n = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      timer  <= '0;
      shift  <= '0;
      opc_o  <= 2'b00;
      cnv_o  <= 1'b0;
      dclk_o <= 1'b0;
      data_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
`ifdef ADC_CNT_CHECK_EN
      shadow <= '0;
      err_o  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      shift  <= shift_n;
      opc_o  <= opc_n;
      cnv_o  <= (state_n == CONV);
      dclk_o <= (state_n == HIGH);
      busy_o <= (state_n != IDLE);
      done_o <= (state_n == DONE);
      if (state_n == DONE) data_o <= shift_n;
`ifdef ADC_CNT_CHECK_EN
      shadow <= shadow_n;
      err_o  <= err_flag;
`endif
    end
  end

  // err_flag is only consumed when the check macro is defined.
  logic unused_ok;
  assign unused_ok = err_flag;

endmodule

// File: tb/tb_adc_read_fsm.sv
// Bench for adc_read_fsm: default-parameter instance plus a NBits=1/ConvCycles=1 corner instance,
// each with a behavioural pulse counter and ADC serial model.
module tb_adc_read_fsm;
  localparam int Width = 6, NBits = 16, ConvCycles = 50, HalfDiv = 2;
  // Spec numbers the done cycle k+1+C+2HN; it is observed just after edge k+C+2HN.
  localparam int DoneOff = ConvCycles + 2 * HalfDiv * NBits;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic             start_i = 1'b0, sdo_i = 1'b0;
  logic [Width-1:0] cnt_i;
  logic [1:0]       opc_o;
  logic             cnv_o, dclk_o, busy_o, done_o;
  logic [NBits-1:0] data_o;
  logic [2:0]       state_o;
`ifdef ADC_CNT_CHECK_EN
  logic             err_o;
`endif

  adc_read_fsm #(.Width(Width), .NBits(NBits), .ConvCycles(ConvCycles), .HalfDiv(HalfDiv)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sdo_i(sdo_i), .cnt_i(cnt_i),
    .opc_o(opc_o), .cnv_o(cnv_o), .dclk_o(dclk_o), .data_o(data_o), .busy_o(busy_o),
    .done_o(done_o),
`ifdef ADC_CNT_CHECK_EN
    .err_o(err_o),
`endif
    .state_o(state_o));

  // corner instance
  logic       c_start = 1'b0, c_sdo = 1'b0;
  logic [1:0] c_cnt, c_opc;
  logic       c_cnv, c_dclk, c_busy, c_done;
  logic [0:0] c_data;
  logic [2:0] c_state;
`ifdef ADC_CNT_CHECK_EN
  logic       c_err;
`endif

  adc_read_fsm #(.Width(2), .NBits(1), .ConvCycles(1), .HalfDiv(2)) u_corner (
    .clk_i(clk), .rst_i(rst_i), .start_i(c_start), .sdo_i(c_sdo), .cnt_i(c_cnt),
    .opc_o(c_opc), .cnv_o(c_cnv), .dclk_o(c_dclk), .data_o(c_data), .busy_o(c_busy),
    .done_o(c_done),
`ifdef ADC_CNT_CHECK_EN
    .err_o(c_err),
`endif
    .state_o(c_state));

  // behavioural counter_r_adc models; inject forces a 3 -> 5 skip
  logic inject = 1'b0;
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) cnt_i <= '0;
    else case (opc_o)
      2'b10:   cnt_i <= (inject && cnt_i == 3) ? Width'(5) : cnt_i + 1'b1;
      2'b01:   cnt_i <= cnt_i;
      default: cnt_i <= '0;
    endcase
  end
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) c_cnt <= '0;
    else case (c_opc)
      2'b10:   c_cnt <= c_cnt + 1'b1;
      2'b01:   c_cnt <= c_cnt;
      default: c_cnt <= '0;
    endcase
  end

  // ADC model (bit index = dclk rising edges seen in this read) and monitors
  logic [NBits-1:0] adc_word = '0;
  int idx = 0, rises = 0, dclk_hi = 0, cnv_cyc = 0, done_cnt = 0;
  logic dclk_prev = 1'b0;
  always @(negedge clk) begin
    if (cnv_o) idx = 0;
    else if (dclk_o && !dclk_prev) idx++;
    if (dclk_o && !dclk_prev) rises++;
    if (dclk_o) dclk_hi++;
    if (cnv_o) cnv_cyc++;
    if (done_o) done_cnt++;
    dclk_prev = dclk_o;
    sdo_i = (idx < NBits) ? adc_word[NBits-1-idx] : 1'b0;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    rises = 0; dclk_hi = 0; cnv_cyc = 0; done_cnt = 0;
  endtask

  // one read; optional stray start pulses at edge offsets pa/pb; returns done offset or -1
  task automatic read_one(input logic [NBits-1:0] word, input int pa, input int pb, output int off);
    adc_word = word;
    clr_mon();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    off = -1;
    for (int j = 1; j <= DoneOff + 20; j++) begin
      start_i = (j == pa || j == pb);
      @(posedge clk); #1;
      if (done_o) begin off = j; break; end
    end
    start_i = 1'b0;
  endtask

  task automatic full_read(input string tag, input logic [NBits-1:0] word);
    int off;
    read_one(word, -5, -5, off);
    check({tag, "_done_off"}, off, DoneOff);
    check({tag, "_data"}, data_o, word);
    check({tag, "_rises"}, rises, NBits);
    check({tag, "_dclk_hi"}, dclk_hi, NBits * HalfDiv);
    check({tag, "_cnv_cyc"}, cnv_cyc, ConvCycles);
`ifdef ADC_CNT_CHECK_EN
    check({tag, "_err"}, err_o, 1'b0);
`endif
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, busy_o, 1'b0);
    check({tag, "_done_width"}, done_o, 1'b0);
  endtask

  initial begin
    int off, off2, gap;
    logic [NBits-1:0] w;
    logic bitv;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_opc", opc_o, 2'b00);
    check("rst_cnv", cnv_o, 1'b0);
    check("rst_dclk", dclk_o, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    full_read("basic", 16'hA5C3);

    for (int r = 0; r < 3; r++) begin
      w = NBits'($urandom_range(0, 65535));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      full_read("rand", w);
    end

    // back-to-back with start held high
    adc_word = 16'h0001;
    start_i = 1'b1;
    off = -1; off2 = -1;
    for (int j = 1; j <= 2 * DoneOff + 40; j++) begin
      @(posedge clk); #1;
      if (done_o && off < 0) begin off = j; adc_word = 16'hFFFF; check("b2b_first_data", data_o, 16'h0001); end
      else if (done_o) begin off2 = j; break; end
    end
    start_i = 1'b0;
    check("b2b_spacing", off2 - off, DoneOff + 2);
    check("b2b_second_data", data_o, 16'hFFFF);
    repeat (DoneOff + 5) @(posedge clk);
    #1;
    check("b2b_stop_busy", busy_o, 1'b0);

    // stray starts in CONV and LOW are ignored
    read_one(16'h3C5A, 10, ConvCycles + 1, off);
    check("ign_done_off", off, DoneOff);
    check("ign_data", data_o, 16'h3C5A);
    repeat (DoneOff + 10) @(posedge clk);
    #1;
    check("ign_done_cnt", done_cnt, 1);

    // reset during the HIGH phase of bit 5
    adc_word = 16'h1234;
    clr_mon();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int j = 0; j < DoneOff && rises < 6; j++) begin @(posedge clk); #1; end
    check("mid_in_high", dclk_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("mid_opc", opc_o, 2'b00);
    check("mid_cnv", cnv_o, 1'b0);
    check("mid_dclk", dclk_o, 1'b0);
    check("mid_data", data_o, '0);
    check("mid_busy", busy_o, 1'b0);
    check("mid_done", done_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("mid_idle_busy", busy_o, 1'b0);
    full_read("after_rst", 16'hBEEF);

`ifdef ADC_CNT_CHECK_EN
    // counter skips 3 -> 5 on the fourth pulse: error at the end of bit 3's HIGH
    inject = 1'b1;
    w = 16'hC9F1;
    read_one(w, -5, -5, off);
    check("err_done_off", off, ConvCycles + 2 * HalfDiv * 4);
    check("err_flag", err_o, 1'b1);
    check("err_partial", data_o, NBits'(w >> (NBits - 4)));
    inject = 1'b0;
    @(posedge clk); #1;
    check("err_clear", err_o, 1'b0);
    check("err_idle", busy_o, 1'b0);
`endif

    // corner instance: one bit, one conversion cycle
    for (int r = 0; r < 2; r++) begin
      bitv = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      c_sdo = bitv;
      c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      gap = -1;
      for (int j = 1; j <= 20; j++) begin
        @(posedge clk); #1;
        if (c_done) begin gap = j; break; end
      end
      check("corner_done_off", gap, 5);
      check("corner_data", c_data, bitv);
      @(posedge clk); #1;
      check("corner_busy_fall", c_busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
